// File: rtl/edib_pkg.sv
// Shared types for the EDIB word receiver: FSM states, status codes and the
// sync-length tolerance.
package edib_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC_A,
    SYNC_B,
    DATA,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    EDIB_ERR_OK  = 2'b00,
    EDIB_ERR_PAR = 2'b01,
    EDIB_ERR_MAN = 2'b10
  } err_e;

  // Allowed deviation of a sync half from its nominal 3H length.
  function automatic int sync_tol(input int half_bit_clks);
    return half_bit_clks / 2;
  endfunction

endpackage

// File: rtl/edib_rx_fifo.sv
// Word FIFO for the EDIB receiver. A pop in the same cycle as a push frees
// the slot, so a push into a full FIFO still succeeds when the head leaves.
module edib_rx_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      level_q;
  logic             push_ok, pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the head is masked while empty
  // instead, which keeps the array as plain RAM.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end

  assign data_o  = empty_o ? '0 : mem_q[rd_q];
  assign level_o = level_q;

endmodule

// File: rtl/edib_word_rx.sv
// EDIB serial word receiver: sync hunt, Manchester decode, odd parity check
// and a word FIFO. Define EDIB_RX_GLITCH_FILTER_EN for a 3-sample majority filter.
module edib_word_rx
  import edib_pkg::*;
#(
  parameter int HALF_BIT_CLKS = 576,
  parameter int DATA_W        = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          RxIn,
  output logic                          RxValid,
  input  logic                          RxReady,
  output logic [DATA_W-1:0]             RxData,
  output logic                          RxType,
  output logic [1:0]                    RxErr,
  output logic [$clog2(FIFO_DEPTH):0]   FifoLevel,
  output logic                          Overflow,
  output logic [7:0]                    SyncErrCnt,
  output logic                          Busy
);

  localparam int H      = HALF_BIT_CLKS;
  localparam int TOL    = sync_tol(HALF_BIT_CLKS);
  localparam int NBITS  = DATA_W + 1;
  localparam int NSAMP  = 2 * NBITS;
  localparam int CNT_W  = $clog2(4 * H + 1);
  localparam int SMP_W  = $clog2(NSAMP);

  localparam logic [CNT_W-1:0] C_HM1  = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] C_HALF = CNT_W'(H / 2);
  localparam logic [CNT_W-1:0] C_3H   = CNT_W'(3 * H);
  localparam logic [CNT_W-1:0] C_LO   = CNT_W'(3 * H - TOL);
  localparam logic [CNT_W-1:0] C_HI   = CNT_W'(3 * H + TOL);
  localparam logic [CNT_W-1:0] C_4H   = CNT_W'(4 * H);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(NSAMP - 1);

  logic sync1_q, sync2_q, s, s_prev_q, edge_det;

`ifdef EDIB_RX_GLITCH_FILTER_EN
  logic dly1_q, dly2_q;
  always_ff @(posedge Clk) begin
    if (Rst) begin
      dly1_q <= 1'b0;
      dly2_q <= 1'b0;
    end else begin
      dly1_q <= sync2_q;
      dly2_q <= dly1_q;
    end
  end
  assign s = (sync2_q & dly1_q) | (sync2_q & dly2_q) | (dly1_q & dly2_q);
`else
  assign s = sync2_q;
`endif

  assign edge_det = s ^ s_prev_q;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;      // RunCnt / sync count / Phase
  logic [SMP_W-1:0]   smp_q, smp_d;
  logic [NSAMP-1:0]   shift_q, shift_d;
  logic               lvl_q, lvl_d, type_q, type_d, push_q, push_d, ovf_q;
  logic [7:0]         serr_q, serr_d;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      s_prev_q <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      smp_q    <= '0;
      shift_q  <= '0;
      lvl_q    <= 1'b0;
      type_q   <= 1'b0;
      push_q   <= 1'b0;
      serr_q   <= '0;
    end else begin
      sync1_q  <= RxIn;
      sync2_q  <= sync1_q;
      s_prev_q <= s;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      smp_q    <= smp_d;
      shift_q  <= shift_d;
      lvl_q    <= lvl_d;
      type_q   <= type_d;
      push_q   <= push_d;
      serr_q   <= serr_d;
    end
  end

  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    smp_d   = smp_q;
    shift_d = shift_q;
    lvl_d   = lvl_q;
    type_d  = type_q;
    push_d  = 1'b0;
    serr_d  = serr_q;
    case (state_q)
      IDLE: if (edge_det) begin
        state_d = SYNC_A;
        cnt_d   = '0;
        lvl_d   = s;
      end
      SYNC_A: begin
        if (edge_det) begin
          if (cnt_q >= C_LO && cnt_q <= C_HI) begin
            state_d = SYNC_B;
            type_d  = lvl_q;
            cnt_d   = CNT_W'(1);  // cycles elapsed since the mid-sync edge
          end else begin
            cnt_d = '0;
            lvl_d = s;
          end
        end else if (cnt_q != C_4H) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SYNC_B: begin
        if (edge_det && cnt_q < C_LO) begin
          if (serr_q != 8'hFF) serr_d = serr_q + 8'd1;
          state_d = SYNC_A;
          cnt_d   = '0;
          lvl_d   = s;
        end else if (cnt_q == C_3H) begin
          state_d = DATA;
          cnt_d   = '0;
          smp_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        cnt_d = (edge_det || cnt_q == C_HM1) ? '0 : cnt_q + CNT_W'(1);
        if (cnt_q == C_HALF) begin
          shift_d = {shift_q[NSAMP-2:0], s};
          smp_d   = smp_q + SMP_W'(1);
          if (smp_q == SMP_LAST) begin
            state_d = DONE;
            push_d  = 1'b1;
          end
        end
      end
      DONE: begin
        // Leave at the end of the parity's second half so a following sync
        // is timed from the true word boundary.
        if (edge_det || cnt_q == C_HM1) begin
          state_d = SYNC_A;
          cnt_d   = '0;
          lvl_d   = s;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [NBITS-1:0] firsts;
  logic             man_err;
  err_e             err;

  always_comb begin
    firsts  = '0;
    man_err = 1'b0;
    for (int j = 0; j < NBITS; j++) begin
      firsts[j] = shift_q[2*j+1];
      if (shift_q[2*j+1] == shift_q[2*j]) man_err = 1'b1;
    end
    if (man_err)      err = EDIB_ERR_MAN;
    else if (^firsts) err = EDIB_ERR_OK;
    else              err = EDIB_ERR_PAR;
  end

  logic [DATA_W+2:0] fifo_dout;
  logic              fifo_full, fifo_empty;

  edib_rx_fifo #(
    .WIDTH(DATA_W + 3),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_i   (Rst),
    .push_i  (push_q),
    .data_i  ({type_q, err, firsts[NBITS-1:1]}),
    .pop_i   (RxReady),
    .data_o  (fifo_dout),
    .level_o (FifoLevel),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge Clk) begin
    if (Rst) ovf_q <= 1'b0;
    else     ovf_q <= push_q && fifo_full && !(RxReady && !fifo_empty);
  end

  assign RxValid    = !fifo_empty;
  assign RxType     = fifo_dout[DATA_W+2];
  assign RxErr      = fifo_dout[DATA_W+1:DATA_W];
  assign RxData     = fifo_dout[DATA_W-1:0];
  assign Overflow   = ovf_q;
  assign SyncErrCnt = serr_q;
  assign Busy       = state_q inside {SYNC_B, DATA, DONE};

endmodule

// File: tb/tb_edib_word_rx.sv
// Scoreboard bench for edib_word_rx: expected words are derived from the
// transmitted half-bit levels and checked by an independent monitor.
module tb_edib_word_rx;

  localparam int H     = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int NP    = DW + 1;

  logic          Clk = 1'b0;
  logic          Rst, RxIn, RxReady;
  logic          RxValid, RxType, Overflow, Busy;
  logic [DW-1:0] RxData;
  logic [1:0]    RxErr;
  logic [LW-1:0] FifoLevel;
  logic [7:0]    SyncErrCnt;

  always #5 Clk = ~Clk;

  edib_word_rx #(.HALF_BIT_CLKS(H), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst), .RxIn(RxIn), .RxValid(RxValid), .RxReady(RxReady),
    .RxData(RxData), .RxType(RxType), .RxErr(RxErr), .FifoLevel(FifoLevel),
    .Overflow(Overflow), .SyncErrCnt(SyncErrCnt), .Busy(Busy)
  );

  typedef struct packed {
    logic          typ;
    logic [1:0]    err;
    logic [DW-1:0] data;
  } word_t;

  word_t exp_q[$];
  int total = 0;
  int bad = 0;
  int ovf_seen = 0;
  int exp_ovf = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every presented head is compared with the scoreboard front.
  always @(negedge Clk) begin
    if (!Rst) begin
      if (Overflow) ovf_seen++;
      if (RxValid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %h expected none", {RxType, RxErr, RxData});
        end else if (RxReady) begin
          check("pop", {RxType, RxErr, RxData}, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          check("hold", {RxType, RxErr, RxData}, exp_q[0]);
        end
      end
    end
  end

  task automatic drive(input logic lvl, input int cyc);
    RxIn = lvl;
    repeat (cyc) @(posedge Clk);
    #1;
  endtask

  function automatic logic good_par(input logic [DW-1:0] d);
    return ~(^d);
  endfunction

  // Send sync plus Manchester halves; man_pair >= 0 sends that bit as "11".
  // stop >= 0 abandons the word after that many data half-bits.
  task automatic send_word(input logic typ, input logic [DW-1:0] data, input logic par,
                           input int man_pair, input bit gap, input bit glitch,
                           input bit expect_push, input int stop);
    logic       hv [2*NP];
    logic [NP-1:0] firsts;
    bit         man;
    word_t      w;
    for (int k = 0; k < NP; k++) begin
      logic b;
      b = (k < DW) ? data[DW-1-k] : par;
      hv[2*k]   = b;
      hv[2*k+1] = !b;
      if (k == man_pair) begin
        hv[2*k]   = 1'b1;
        hv[2*k+1] = 1'b1;
      end
    end
    man = 1'b0;
    for (int k = 0; k < NP; k++) begin
      firsts[NP-1-k] = hv[2*k];
      if (hv[2*k] == hv[2*k+1]) man = 1'b1;
    end
    w.typ  = typ;
    w.data = firsts[NP-1:1];
    w.err  = man ? 2'b10 : ((^firsts) ? 2'b00 : 2'b01);
    if (expect_push && stop < 0) exp_q.push_back(w);
    if (gap) drive(!typ, 6 * H);
    drive(typ, 3 * H);
    drive(!typ, 3 * H);
    for (int i = 0; i < 2 * NP; i++) begin
      if (i == stop) return;
      if (glitch && (i % 3 == 1)) begin
        drive(hv[i], 2);
        drive(!hv[i], 1);
        drive(hv[i], H - 3);
      end else begin
        drive(hv[i], H);
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge Clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, RxValid, 0);
    check({tag, "_level"}, FifoLevel, 0);
    check({tag, "_data"}, RxData, 0);
    check({tag, "_type"}, RxType, 0);
    check({tag, "_err"}, RxErr, 0);
    check({tag, "_ovf"}, Overflow, 0);
    check({tag, "_serr"}, SyncErrCnt, 0);
    check({tag, "_busy"}, Busy, 0);
  endtask

  initial begin
    logic [DW-1:0] d;
    int n;
    Rst = 1'b1;
    RxIn = 1'b0;
    RxReady = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check_all_zero("reset");
    Rst = 1'b0;
    drive(1'b0, 10);

    // 1: command word of all ones, plus first-word latency bound
    send_word(1'b1, 16'hFFFF, 1'b1, -1, 1'b1, 1'b0, 1'b1, -1);
    n = 0;
    while (!RxValid && n < 8) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check("t1_valid_latency", RxValid, 1);
    wait_drain(200);

    // 2: command immediately followed by a data word
    send_word(1'b1, 16'hFFFF, 1'b1, -1, 1'b1, 1'b0, 1'b1, -1);
    send_word(1'b0, 16'h0001, 1'b0, -1, 1'b0, 1'b0, 1'b1, -1);
    wait_drain(200);

    // 3: parity error, then a Manchester error
    send_word(1'b0, 16'h0003, 1'b0, -1, 1'b1, 1'b0, 1'b1, -1);
    d = 16'($urandom);
    send_word(1'b1, d, good_par(d), $urandom_range(0, NP - 1), 1'b1, 1'b0, 1'b1, -1);
    wait_drain(200);

    // randomized mix of types, data, parity and Manchester faults
    for (int i = 0; i < 8; i++) begin
      logic typ, par;
      int mp;
      bit gap;
      typ = 1'($urandom_range(0, 1));
      d   = 16'($urandom);
      par = ($urandom_range(0, 3) == 0) ? !good_par(d) : good_par(d);
      mp  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NP - 1)) : -1;
      gap = (i == 0) || ($urandom_range(0, 1) == 1);
      send_word(typ, d, par, mp, gap, 1'b0, 1'b1, -1);
    end
    wait_drain(200);

    // 4: consumer stalled, five good words into a four-entry FIFO
    RxReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = 16'($urandom);
      send_word(1'($urandom_range(0, 1)), d, good_par(d), -1, 1'b1, 1'b0, i < DEPTH, -1);
      if (i >= DEPTH) exp_ovf++;
    end
    repeat (10) @(posedge Clk);
    #1;
    check("t4_level", FifoLevel, DEPTH);
    check("t4_overflow", ovf_seen, exp_ovf);
    RxReady = 1'b1;
    wait_drain(50);
    check("t4_level_drained", FifoLevel, 0);

    // 5: aborted sync, then a valid word
    check("t5_serr_before", SyncErrCnt, 0);
    drive(1'b0, 6 * H);
    drive(1'b1, 3 * H);
    drive(1'b0, H);
    drive(1'b1, 6 * H);
    check("t5_serr", SyncErrCnt, 1);
    check("t5_no_push", FifoLevel, 0);
    d = 16'($urandom);
    send_word(1'b1, d, good_par(d), -1, 1'b1, 1'b0, 1'b1, -1);
    wait_drain(200);

    // 6: reset in the middle of a word with a word still queued
    RxReady = 1'b0;
    d = 16'($urandom);
    send_word(1'b0, d, good_par(d), -1, 1'b1, 1'b0, 1'b1, -1);
    n = 0;
    while (!RxValid && n < 20) begin
      @(posedge Clk);
      #1;
      n++;
    end
    send_word(1'b1, 16'hA5C3, good_par(16'hA5C3), -1, 1'b1, 1'b0, 1'b0, 10);
    check("t6_busy_pre", Busy, 1);
    check("t6_valid_pre", RxValid, 1);
    Rst = 1'b1;
    exp_q.delete();
    @(posedge Clk);
    #1;
    check_all_zero("t6_reset");
    Rst = 1'b0;
    RxReady = 1'b1;
    d = 16'($urandom);
    send_word(1'b1, d, good_par(d), -1, 1'b1, 1'b0, 1'b1, -1);
    wait_drain(200);

`ifdef EDIB_RX_GLITCH_FILTER_EN
    // single-cycle pulses inside half-bits must not disturb decoding
    for (int i = 0; i < 2; i++) begin
      d = 16'($urandom);
      send_word(1'(i), d, good_par(d), -1, 1'b1, 1'b1, 1'b1, -1);
    end
    wait_drain(200);
`endif

    repeat (5) @(posedge Clk);
    #1;
    check("end_overflow", ovf_seen, exp_ovf);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
